sysbus_responder: RTL and testbench

SYSBUS_RESPONDER -- requirements
Module: sysbus_responder

---
 rtl/sysbus_pkg.sv | 23 ++
 rtl/sysbus_fifo.sv | 67 ++++++
 rtl/sysbus_responder.sv | 127 ++++++++++++
 tb/tb_sysbus_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysbus_pkg.sv
// sysbus_pkg: register map, bit positions and default widths
// shared by the sysbus responder and its FIFO.
package sysbus_pkg;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_OP_W   = 3;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CTRL    = 2'd2,
    REG_SCRATCH = 2'd3
  } reg_off_e;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;

endpackage

// File: rtl/sysbus_fifo.sv
// sysbus_fifo: power-of-2 output FIFO; a push while full is
// accepted only when a pop frees the slot on the same edge.
module sysbus_fifo #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [WORD_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic [WORD_W-1:0] head
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push;
  logic              do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = cnt_q;
  assign head    = empty ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush && do_push)
      mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/sysbus_responder.sv
// sysbus_responder: register-mapped bus slave feeding a stream FIFO.
// Define SYSBUS_RESP_OVF_EN for the sticky overflow flag.
module sysbus_responder
  import sysbus_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int OP_W   = DEF_OP_W,
  parameter int BASE   = 0,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  inout  wire  [WORD_W-1:0] sysbus,
  input  logic              load_addr,
  input  logic              rd,
  input  logic              wr,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int AW = WORD_W - OP_W;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]     addr_q, addr_d;
  logic              en_q, en_d;
  logic [WORD_W-1:0] scr_q, scr_d;
  logic              sel, rd_en, wr_en;
  reg_off_e          off;
  logic              push, pop, flush;
  logic              full, empty, ovf;
  logic [CW-1:0]     count;
  logic [WORD_W-1:0] head, status, rdata;

  assign sel   = (addr_q[AW-1:2] == (AW-2)'(BASE));
  assign off   = reg_off_e'(addr_q[1:0]);
  assign rd_en = rd & ~wr & sel & ~reset;
  assign wr_en = wr & ~rd & sel & ~reset;

  assign push  = wr_en & (off == REG_DATA);
  assign flush = wr_en & (off == REG_CTRL)
               & sysbus[CTRL_FLUSH];
  assign pop   = out_valid & out_ready;

  assign out_valid = en_q & ~empty;
  assign out_data  = head;
  assign sysbus    = rd_en ? rdata : 'z;

  sysbus_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (sysbus),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  always_comb begin
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL]  = full;
    status[ST_OVF]   = ovf;
    status[ST_CNT_LSB +: CW] = count;
  end

  always_comb begin
    rdata = '0;
    unique case (off)
      REG_DATA:    rdata = head;
      REG_STATUS:  rdata = status;
      REG_CTRL:    rdata[CTRL_EN] = en_q;
      REG_SCRATCH: rdata = scr_q;
    endcase
  end

  always_comb begin
    addr_d = load_addr ? sysbus[AW-1:0] : addr_q;
    en_d   = en_q;
    scr_d  = scr_q;
    if (wr_en && off == REG_CTRL)
      en_d = sysbus[CTRL_EN];
    if (wr_en && off == REG_SCRATCH)
      scr_d = sysbus;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      en_q   <= 1'b0;
      scr_q  <= '0;
    end else begin
      addr_q <= addr_d;
      en_q   <= en_d;
      scr_q  <= scr_d;
    end
  end

`ifdef SYSBUS_RESP_OVF_EN
  logic ovf_q, ovf_d;

  // A drop on the same edge as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && off == REG_STATUS && sysbus[ST_OVF])
      ovf_d = 1'b0;
    if (push && full && !pop)
      ovf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sysbus_responder.sv
// tb_sysbus_responder: directed scenarios plus random traffic checked
// against a queue-based model; the bus is pulled high when idle.
module tb_sysbus_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_addr = 1'b0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic       out_ready = 1'b0;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_dat = 8'h00;
  tri1  [7:0] sysbus;
  logic [7:0] out_data;
  logic       out_valid;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_q [$];
  logic       m_en = 1'b0;
  logic [7:0] m_scr = 8'h00;
  logic       m_ovf = 1'b0;
  logic [4:0] m_addr = 5'd0;
  logic       m_known = 1'b0;

  logic [7:0] last_bus;
  logic [7:0] last_data;
  logic       last_valid;

  assign sysbus = tb_oe ? tb_dat : 'z;

  always #5 clock = ~clock;

  sysbus_responder #(
    .WORD_W (8),
    .OP_W   (3),
    .BASE   (0),
    .DEPTH  (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .sysbus    (sysbus),
    .load_addr (load_addr),
    .rd        (rd),
    .wr        (wr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, check combinational outputs, advance model.
  task automatic step(input logic rs, input logic ld,
                      input logic r, input logic w,
                      input logic [7:0] d, input logic rdy);
    logic       sel, rdv, wrv, popv, full0;
    logic [1:0] off;
    logic [7:0] rv, eb, hd;
    int         n;
    reset = rs; load_addr = ld; rd = r; wr = w;
    out_ready = rdy; tb_dat = d;
    tb_oe = ld | (w & ~r);
    #1;
    n   = m_q.size();
    sel = (m_addr[4:2] == 3'd0);
    off = m_addr[1:0];
    rdv = !rs && r && !w && sel;
    wrv = !rs && w && !r && sel;
    hd  = (n != 0) ? m_q[0] : 8'h00;
    case (off)
      2'd0:    rv = hd;
      2'd1:    rv = {4'(n), 1'b0, m_ovf, n == 4, n == 0};
      2'd2:    rv = {7'd0, m_en};
      default: rv = m_scr;
    endcase
    eb = tb_oe ? d : (rdv ? rv : 8'hFF);
    last_bus = sysbus;
    last_valid = out_valid;
    last_data = out_data;
    chk("bus", sysbus, eb);
    if (m_known) begin
      chk("valid", {7'd0, out_valid},
          {7'd0, m_en && n != 0});
      chk("data", out_data, hd);
    end
    @(posedge clock);
    if (rs) begin
      m_q.delete();
      m_en = 1'b0; m_scr = 8'h00;
      m_ovf = 1'b0; m_addr = 5'd0;
      m_known = 1'b1;
    end else begin
      popv  = m_en && n != 0 && rdy;
      full0 = (n == 4);
      if (wrv && off == 2'd2 && d[1]) begin
        m_q.delete();
      end else begin
        if (popv) void'(m_q.pop_front());
        if (wrv && off == 2'd0) begin
          if (!full0 || popv) m_q.push_back(d);
`ifdef SYSBUS_RESP_OVF_EN
          else m_ovf = 1'b1;
`endif
        end
      end
`ifdef SYSBUS_RESP_OVF_EN
      if (wrv && off == 2'd1 && d[2] &&
          !(wrv && off == 2'd0))
        m_ovf = 1'b0;
`endif
      if (wrv && off == 2'd2) m_en = d[0];
      if (wrv && off == 2'd3) m_scr = d;
      if (ld) m_addr = d[4:0];
    end
    @(negedge clock);
  endtask

  task automatic ldA(input logic [7:0] a, input logic rdy);
    step(1'b0, 1'b1, 1'b0, 1'b0, a, rdy);
  endtask

  task automatic wrD(input logic [7:0] d, input logic rdy);
    step(1'b0, 1'b0, 1'b0, 1'b1, d, rdy);
  endtask

  task automatic rdR(input logic rdy);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, rdy);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, rdy);
  endtask

  initial begin
    logic [7:0] st_ovf;
    logic [7:0] drain [4];
`ifdef SYSBUS_RESP_OVF_EN
    st_ovf = 8'h46;
`else
    st_ovf = 8'h42;
`endif
    @(negedge clock);

    // reset with rd held high
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_bus_z", last_bus, 8'hFF);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_bus_z2", last_bus, 8'hFF);
    chk("rst_valid", {7'd0, last_valid}, 8'h00);
    ldA(8'h01, 1'b0);
    chk("rst_data", last_data, 8'h00);
    rdR(1'b0);
    chk("rst_status", last_bus, 8'h01);

    // scratch write, unselected block, rd+wr together
    ldA(8'h03, 1'b0);
    wrD(8'hA5, 1'b0);
    rdR(1'b0);
    chk("scratch_rd", last_bus, 8'hA5);
    ldA(8'h07, 1'b0);
    rdR(1'b0);
    chk("unsel_z", last_bus, 8'hFF);
    ldA(8'h03, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0);
    chk("rdwr_z", last_bus, 8'hFF);
    rdR(1'b0);
    chk("scratch_kept", last_bus, 8'hA5);

    // fill while disabled, overflow, then drain
    ldA(8'h00, 1'b0);
    wrD(8'h11, 1'b0);
    wrD(8'h22, 1'b0);
    wrD(8'h33, 1'b0);
    wrD(8'h44, 1'b0);
    ldA(8'h01, 1'b0);
    rdR(1'b0);
    chk("full_status", last_bus, 8'h42);
    ldA(8'h00, 1'b0);
    wrD(8'h55, 1'b0);
    ldA(8'h01, 1'b0);
    rdR(1'b0);
    chk("ovf_status", last_bus, st_ovf);
    ldA(8'h02, 1'b1);
    wrD(8'h01, 1'b1);
    drain = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("drain_valid", {7'd0, last_valid}, 8'h01);
      chk("drain_data", last_data, drain[i]);
    end
    idle(1'b1);
    chk("drain_end", {7'd0, last_valid}, 8'h00);

    // clear ovf, then push and pop together while full
    ldA(8'h01, 1'b0);
    wrD(8'h04, 1'b0);
    ldA(8'h00, 1'b0);
    wrD(8'h01, 1'b0);
    wrD(8'h02, 1'b0);
    wrD(8'h03, 1'b0);
    wrD(8'h04, 1'b0);
    ldA(8'h01, 1'b0);
    rdR(1'b0);
    chk("full2_status", last_bus, 8'h42);
    ldA(8'h00, 1'b0);
    wrD(8'h99, 1'b1);
    ldA(8'h01, 1'b0);
    rdR(1'b0);
    chk("pushpop_status", last_bus, 8'h42);
    drain = '{8'h02, 8'h03, 8'h04, 8'h99};
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("order_data", last_data, drain[i]);
    end
    idle(1'b1);
    chk("order_end", {7'd0, last_valid}, 8'h00);

    // flush wins over a pop on the same edge
    ldA(8'h00, 1'b0);
    wrD(8'h0A, 1'b0);
    wrD(8'h0B, 1'b0);
    wrD(8'h0C, 1'b0);
    ldA(8'h02, 1'b1);
    wrD(8'h03, 1'b1);
    idle(1'b1);
    chk("flush_valid", {7'd0, last_valid}, 8'h00);
    ldA(8'h01, 1'b0);
    rdR(1'b0);
    chk("flush_status", last_bus, 8'h01);
    ldA(8'h02, 1'b0);
    rdR(1'b0);
    chk("flush_ctrl", last_bus, 8'h01);

    // reset mid-stream
    ldA(8'h00, 1'b0);
    wrD(8'h21, 1'b0);
    wrD(8'h22, 1'b0);
    wrD(8'h23, 1'b0);
    wrD(8'h24, 1'b0);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("pre_rst_head", last_data, 8'h23);
    idle(1'b0);
    chk("post_rst_valid", {7'd0, last_valid}, 8'h00);
    ldA(8'h01, 1'b0);
    rdR(1'b0);
    chk("post_rst_status", last_bus, 8'h01);
    ldA(8'h02, 1'b0);
    rdR(1'b0);
    chk("post_rst_ctrl", last_bus, 8'h00);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int         k;
      logic       rs, rdy;
      logic [7:0] d, a;
      k   = $urandom_range(0, 99);
      d   = 8'($urandom);
      a   = {3'($urandom), 5'($urandom)};
      if ($urandom_range(0, 3) != 0) a[4:2] = 3'd0;
      rs  = ($urandom_range(0, 79) == 0);
      rdy = 1'($urandom);
      if (k < 25)
        step(rs, 1'b1, 1'b0, $urandom_range(0, 3) == 0, a, rdy);
      else if (k < 55)
        step(rs, 1'b0, 1'b0, 1'b1, d, rdy);
      else if (k < 85)
        step(rs, 1'b0, 1'b1, 1'b0, d, rdy);
      else if (k < 90)
        step(rs, 1'b0, 1'b1, 1'b1, d, rdy);
      else
        step(rs, 1'b0, 1'b0, 1'b0, d, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
